// File: rtl/divider_sequencer_if.sv
// Ratio-update handshake between the control logic and divider_sequencer.
// The master holds cfg_valid/cfg_div until it sees cfg_ready.
interface divider_sequencer_if #(
    parameter int WIDTH = 26
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/divider_sequencer.sv
// Programmable clock-enable divider: tick pulse, 50% clk_out, start/stop,
// one-shot, and ratio updates that only land on a period boundary.
module divider_sequencer #(
    parameter int               WIDTH       = 26,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(49999999)
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                oneshot,
    divider_sequencer_if.slave  cfg,
    output logic                tick,
    output logic                clk_out,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             os_q, os_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             clk_q, clk_d;
    logic             busy_q;
    logic             term;
    logic             xfer;
    logic             go_idle;

    assign term    = (state_q == RUN) && (cnt_q == div_q);
    assign xfer    = cfg.cfg_valid && !pend_q;
    assign go_idle = (state_q == RUN) && (state_d == IDLE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEFAULT_DIV;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            os_q       <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            clk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            os_q       <= os_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            clk_q      <= clk_d;
            busy_q     <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && !stop) state_d = RUN;
            RUN:  if (stop || (term && os_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = '0;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        os_d       = os_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        clk_d      = 1'b0;
        if (state_q == IDLE) begin
            if (start && !stop) os_d = oneshot;
            if (xfer) div_d = cfg.cfg_div;
        end else begin
            if (stop) begin
                cnt_d = '0;
            end else if (term) begin
                tick_d = 1'b1;
                done_d = os_q;
                clk_d  = ~clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                clk_d = clk_q;
            end
            // A ratio taken while leaving RUN would never see another
            // boundary, so it goes straight into div_reg.
            if (pend_q && (stop || term)) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
            end else if (xfer && go_idle) begin
                div_d = cfg.cfg_div;
            end else if (xfer) begin
                pend_div_d = cfg.cfg_div;
                pend_d     = 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = ~pend_q;
    assign tick          = tick_q;
    assign done          = done_q;
    assign clk_out       = clk_q;
    assign busy          = busy_q;
    assign count         = cnt_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer at WIDTH=8, DEFAULT_DIV=3.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_divider_sequencer;

    localparam int WIDTH = 8;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic             tick;
    logic             clk_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    divider_sequencer_if #(.WIDTH(WIDTH)) cfg ();

    divider_sequencer #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(8'd3)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .oneshot(oneshot),
        .cfg    (cfg),
        .tick   (tick),
        .clk_out(clk_out),
        .busy   (busy),
        .done   (done),
        .count  (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] d);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = d;
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        oneshot       = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        step();
        step();
        check("rst_count", 32'(count), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_clk", 32'(clk_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cfg.cfg_ready), 1);
        reset = 1'b1;
        step();

        // free run at default ratio 3
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_busy", 32'(busy), 1);
        check("run_cnt0", 32'(count), 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("run_tick", 32'(tick), 32'(k % 4 == 0));
            check("run_cnt", 32'(count), 32'(k % 4));
            check("run_clk", 32'(clk_out), 32'((k / 4) % 2));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop1_busy", 32'(busy), 0);
        check("stop1_clk", 32'(clk_out), 0);

        // ratio 1 offered mid-period
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("cfg_ready_pre", 32'(cfg.cfg_ready), 1);
        offer(8'd1);
        step();
        cfg.cfg_valid = 1'b0;
        check("cfg_ready_low", 32'(cfg.cfg_ready), 0);
        check("cfg_cnt2", 32'(count), 2);
        step();
        check("cfg_cnt3", 32'(count), 3);
        step();
        check("cfg_tick_old", 32'(tick), 1);
        check("cfg_ready_back", 32'(cfg.cfg_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("div1_tick", 32'(tick), 32'(k % 2 == 0));
            check("div1_cnt", 32'(count), 32'(k % 2));
        end

        // ratio written directly in IDLE, then offer on a terminal cycle
        stop = 1'b1;
        step();
        stop = 1'b0;
        offer(8'd3);
        step();
        cfg.cfg_valid = 1'b0;
        check("idle_ready", 32'(cfg.cfg_ready), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("term_cnt3", 32'(count), 3);
        offer(8'd5);
        step();
        cfg.cfg_valid = 1'b0;
        check("term_tick", 32'(tick), 1);
        check("term_ready", 32'(cfg.cfg_ready), 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("term_next_tick", 32'(tick), 32'(k == 4 || k == 10));
            if (k == 4) check("term_ready_back", 32'(cfg.cfg_ready), 1);
        end

        // one-shot at ratio 3
        stop = 1'b1;
        step();
        stop = 1'b0;
        offer(8'd3);
        step();
        cfg.cfg_valid = 1'b0;
        oneshot = 1'b1;
        start   = 1'b1;
        step();
        oneshot = 1'b0;
        start   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("os_tick", 32'(tick), 32'(k == 4));
            check("os_done", 32'(done), 32'(k == 4));
            check("os_clk", 32'(clk_out), 32'(k == 4));
            if (k != 4) check("os_busy", 32'(busy), 32'(k < 4));
        end

        // start+stop together, then stop mid-period
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 32'(busy), 0);
        check("ss_cnt", 32'(count), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_cnt2", 32'(count), 2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("mid_busy", 32'(busy), 0);
        check("mid_cnt", 32'(count), 0);
        check("mid_clk", 32'(clk_out), 0);
        check("mid_tick", 32'(tick), 0);
        step();
        check("mid_hold", 32'(count), 0);

        // asynchronous reset with a pending ratio
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        check("ar_clk_pre", 32'(clk_out), 1);
        offer(8'd7);
        step();
        cfg.cfg_valid = 1'b0;
        check("ar_ready_pre", 32'(cfg.cfg_ready), 0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_cnt", 32'(count), 0);
        check("ar_clk", 32'(clk_out), 0);
        check("ar_ready", 32'(cfg.cfg_ready), 1);
        #2;
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("ar_div_tick", 32'(tick), 32'(k == 4 || k == 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
